// File: rtl/result_pkg.sv
// result_pkg: shared types and constants for the result collector.
// Entries are packed {class, float}; classification is done on raw IEEE-754 bits.
package result_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  localparam logic [31:0] THRESH_HALF = 32'h3F00_0000;
  localparam int          ENTRY_W     = 33;

  // Positive, non-NaN and magnitude >= 0.5; +Inf lands in class 1 naturally.
  function automatic logic classify(input logic [31:0] f);
    logic is_nan;
    is_nan = (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    return !f[31] && (f[30:0] >= THRESH_HALF[30:0]) && !is_nan;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous FIFO with a registered head entry.
// A push is accepted when full if a pop happens on the same edge.
module result_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int ENTRY_W    = 33
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic               head_valid,
  output logic [ENTRY_W-1:0] head_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0] head_q, head_d;
  logic               valid_q, valid_d;
  logic               do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    valid_d  = (wr_ptr_d != rd_ptr_d);
    head_d   = head_q;
    // The next head is either the entry being written right now or one already stored.
    if (valid_d) begin
      if (do_push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
        head_d = push_data;
      end else begin
        head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign head_valid = valid_q;
  assign head_data  = head_q;

endmodule

// File: rtl/result_collector.sv
// result_collector: samples the output layer's sigmoid once per index window,
// classifies it against 0.5 and queues it. Define RESULT_STATS_EN for push counters.
module result_collector
  import result_pkg::*;
#(
  parameter int COUNTER_END = 5,
  parameter int PIPE_LAT    = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] index,
  input  logic [31:0] data_in,
  input  logic        out_ready,
  input  logic        clear_ovf,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_class,
  output logic        overflow,
  output logic [15:0] pos_count,
  output logic [15:0] total_count
);

  localparam int            CW       = $clog2(COUNTER_END + 1);
  localparam logic [31:0]   LAST_IDX = 32'(COUNTER_END - 1);
  localparam logic [CW-1:0] LAT_INIT = CW'(PIPE_LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [31:0]        prev_index_q, prev_index_d;
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               overflow_q, overflow_d;
  logic               wrap, capture, pop, push_ok, drop;
  logic               fifo_full, fifo_empty, head_valid;
  logic [ENTRY_W-1:0] push_entry, head_data;

  always_comb begin
    prev_index_d = index;
    wrap         = (prev_index_q == LAST_IDX) && (index == 32'd0);
    state_d      = state_q;
    cnt_d        = cnt_q;
    capture      = 1'b0;
    case (state_q)
      IDLE: begin
        if (wrap) begin
          if (PIPE_LAT == 0) begin
            state_d = CAPTURE;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push_entry = {classify(data_in), data_in};
    pop        = head_valid && out_ready;
    push_ok    = capture && (!fifo_full || pop);
    drop       = capture && !push_ok;
    // A drop in the same cycle as a clear leaves the flag set.
    overflow_d = drop ? 1'b1 : (clear_ovf ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      prev_index_q <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      overflow_q   <= 1'b0;
    end else begin
      prev_index_q <= prev_index_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  result_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ENTRY_W    (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .srst       (rstn),
    .push       (capture),
    .push_data  (push_entry),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  assign out_valid = head_valid && !fifo_empty;
  assign out_data  = head_data[31:0];
  assign out_class = head_data[ENTRY_W-1];
  assign overflow  = overflow_q;

`ifdef RESULT_STATS_EN
  logic [15:0] pos_count_q, pos_count_d;
  logic [15:0] total_count_q, total_count_d;

  always_comb begin
    pos_count_d   = pos_count_q;
    total_count_d = total_count_q;
    if (push_ok) begin
      total_count_d = total_count_q + 16'd1;
      if (push_entry[ENTRY_W-1]) begin
        pos_count_d = pos_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      pos_count_q   <= '0;
      total_count_q <= '0;
    end else begin
      pos_count_q   <= pos_count_d;
      total_count_q <= total_count_d;
    end
  end

  assign pos_count   = pos_count_q;
  assign total_count = total_count_q;
`else
  assign pos_count   = '0;
  assign total_count = '0;
`endif

endmodule

// File: doc/result_collector.md
# result_collector

Back end of the output layer: watches the layer's sequencing index, samples the sigmoid output once per accumulation window, and classifies it against a 0.5 threshold. The sample and its class go into a small FIFO that drains through a valid/ready handshake to the host-side reader. It turns the output layer's free-running, window-based output into discrete, flow-controlled results.

## Interface
- `COUNTER_END`, 5, window length of the layer's index counter (index runs 0..COUNTER_END-1); must equal the layer's value.
- `PIPE_LAT`, 2, cycles between window wrap and a stable `data_in`; legal range 0..COUNTER_END-2.
- `FIFO_DEPTH`, 4, result entries; power of two, ≥2.
- `clk` input 1: single clock, all logic on rising edge.
- `rstn` input 1: synchronous, active-high reset.
- `index` input 32: the output layer's weight/data index.
- `data_in` input 32: IEEE-754 single-precision sigmoid output of the layer.
- `out_ready` input 1: downstream accepts the head entry.
- `clear_ovf` input 1: clears the sticky overflow flag.
- `out_valid` output 1: head entry is present.
- `out_data` output 32: captured float of the head entry.
- `out_class` output 1: class bit of the head entry.
- `overflow` output 1: sticky flag, a result was dropped.
- `pos_count` output 16: positive results pushed (RESULT_STATS_EN only).
- `total_count` output 16: results pushed (RESULT_STATS_EN only).

## Operation
- Wrap detect: registered `prev_index`; wrap = (`prev_index` == COUNTER_END-1) && (`index` == 0). `prev_index` resets to 0.
- FSM states:
  - IDLE: on wrap, load delay counter with PIPE_LAT and go to WAIT. If PIPE_LAT = 0, go directly to CAPTURE.
  - WAIT: decrement the counter. At 1, go to CAPTURE. Wraps seen in WAIT are ignored.
  - CAPTURE: sample `data_in`, push the entry, return to IDLE. A wrap on this cycle is ignored.
- Classify: class = (`data_in`[31] == 0) && (`data_in`[30:0] ≥ 31'h3F000000) && the value is not NaN.
  - NaN means exponent all ones with a nonzero mantissa.
  - +Inf counts as class 1. Any negative value, including -0, is class 0.
  - The comparison is unsigned on the magnitude bits; there is no float unit.
- Push: accepted if the FIFO is not full, or if a pop happens on the same cycle. Otherwise the entry is dropped and `overflow` is set.
- Pop: occurs when `out_valid` && `out_ready`. `out_data` and `out_class` are the head entry; they are held stable while `out_valid` && !`out_ready`.
- Empty FIFO: `out_valid` = 0 and outputs show the last head value (0 after reset).
- `overflow`: set by a drop, cleared by `clear_ovf`. If both occur on the same cycle, set wins.
- Reset (at any time, including mid-window or mid-drain) does the following:
  - FSM → IDLE and the delay counter is cleared.
  - FIFO is emptied.
  - All outputs → 0.
  - Statistics → 0.

## Timing
- The wrap is visible on the edge where `index` becomes 0. The FSM enters WAIT on the next edge.
- `data_in` is sampled in CAPTURE, PIPE_LAT+1 cycles after the wrap edge (1 cycle when PIPE_LAT = 0).
- The entry is written at the end of the CAPTURE cycle. With an empty FIFO, `out_valid` is high the following cycle.
- Pop takes effect at the clock edge. A new head appears in the next cycle, so back-to-back pops give full throughput.
- Statistics counters update on the same edge as an accepted push and wrap at 16'hFFFF → 0.

## Configuration
- `RESULT_STATS_EN` defined: `pos_count` and `total_count` are implemented.
- Not defined: those ports are still present but tied to 0, and no counter flops are generated.

## Structure
- `result_pkg` holds:
  - the FSM state enum (IDLE, WAIT, CAPTURE);
  - `THRESH_HALF` = 32'h3F000000;
  - `ENTRY_W` = 33, packed as {class, float}.
- Sub-module `result_fifo` is a synchronous FIFO with parameters FIFO_DEPTH and ENTRY_W.
  - It has push/pop, full/empty, and registered head outputs.
  - It supports simultaneous push and pop when full.

## Test plan
- `data_in` = 32'h3F400000 (0.75), one window, `out_ready` = 1 → single pop with `out_data` = 3F400000, `out_class` = 1, `out_valid` high for one cycle.
- Boundary classification across four windows → classes in order 1, 0, 0, 0:
  - 32'h3F000000 (0.5)
  - 32'h3E800000 (0.25)
  - 32'hBF000000 (-0.5)
  - 32'h7FC00000 (NaN)
- `out_ready` = 0 for 5 windows → 4 entries held, `overflow` = 1 after the 5th. Draining then returns the first 4 samples in order. `clear_ovf` → `overflow` = 0.
- FIFO full with a pop and a CAPTURE on the same cycle → no drop, `overflow` stays 0, and the FIFO is still full afterward.
- Assert `rstn` during WAIT with 2 entries queued → next cycle `out_valid` = 0, `overflow` = 0, and the next capture happens only after a fresh wrap.
- RESULT_STATS_EN, 6 windows with 4 positive results → `pos_count` = 4, `total_count` = 6. With the macro undefined, both stay 0.
